// File: rtl/jram_arbiter_if.sv
// Bundle of the two requester ports and the RAM bus seen by jram_arbiter.
// slave: the arbiter's view. master: requesters plus the RAM read-data source.
interface jram_arbiter_if;
    // Requester port 0
    logic       req0;
    logic       rw0;
    logic [7:0] addr0;
    logic [7:0] wdata0;
    logic       ack0;
    logic [7:0] rdata0;
    // Requester port 1
    logic       req1;
    logic       rw1;
    logic [7:0] addr1;
    logic [7:0] wdata1;
    logic       ack1;
    logic [7:0] rdata1;
    // Status and RAM bus
    logic       busy;
    logic [7:0] bas;
    logic       wsa;
    logic [7:0] bis;
    logic       ws;
    logic       we;
    logic [7:0] bos;

    modport slave (
        input  req0, rw0, addr0, wdata0,
        input  req1, rw1, addr1, wdata1,
        input  bos,
        output ack0, rdata0, ack1, rdata1,
        output busy, bas, wsa, bis, ws, we
    );

    modport master (
        output req0, rw0, addr0, wdata0,
        output req1, rw1, addr1, wdata1,
        output bos,
        input  ack0, rdata0, ack1, rdata1,
        input  busy, bas, wsa, bis, ws, we
    );
endinterface

// File: rtl/jram_arbiter.sv
// Round-robin two-port arbiter and strobe sequencer for the 256 x 8 RAM.
// One transaction at a time: MAR load (wsa), then a write set (ws) or a read window (we).
module jram_arbiter (
    input logic           clk,
    input logic           reset,
    jram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAhold,
        StWset,
        StWhold,
        StRd,
        StAck
    } state_e;

    state_e     state_q, state_d;
    logic       last_q;   // port granted most recently
    logic       gnt_q;    // port owning the transaction in flight
    logic       gnt_d;
    logic       rw_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] rdata0_q;
    logic [7:0] rdata1_q;

    // Winner among pending requests; a tie goes to the port not granted last.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            gnt_d = ~last_q;
        end else begin
            gnt_d = bus.req1 & ~bus.req0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; IDLE is visited between every pair of transactions.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.req0 || bus.req1) state_d = StAddr;
            StAddr:  state_d = StAhold;
            StAhold: state_d = rw_q ? StWset : StRd;
            StWset:  state_d = StWhold;
            StWhold: state_d = StAck;
            StRd:    state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Grant latching, read capture and pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
        end else begin
            // Request fields are frozen here; later changes by the requester are ignored.
            if (state_q == StIdle && (bus.req0 || bus.req1)) begin
                gnt_q  <= gnt_d;
                rw_q   <= gnt_d ? bus.rw1    : bus.rw0;
                addr_q <= gnt_d ? bus.addr1  : bus.addr0;
                data_q <= gnt_d ? bus.wdata1 : bus.wdata0;
            end
            if (state_q == StRd) begin
                if (gnt_q) begin
                    rdata1_q <= bus.bos;
                end else begin
                    rdata0_q <= bus.bos;
                end
            end
            if (state_q == StAck) begin
                last_q <= gnt_q;
            end
        end
    end

    // Strobes and buses decoded from the state; at most one strobe per state.
    always_comb begin
        bus.busy = (state_q != StIdle);
        bus.wsa  = 1'b0;
        bus.ws   = 1'b0;
        bus.we   = 1'b0;
        bus.bas  = 8'h00;
        bus.bis  = 8'h00;
        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        unique case (state_q)
            StAddr: begin
                bus.wsa = 1'b1;
                bus.bas = addr_q;
            end
            StAhold: bus.bas = addr_q;  // held so the MAR sees a stable address as wsa falls
            StWset: begin
                bus.ws  = 1'b1;
                bus.bis = data_q;
            end
            StWhold: bus.bis = data_q;
            StRd:    bus.we  = 1'b1;
            StAck: begin
                bus.ack0 = ~gnt_q;
                bus.ack1 = gnt_q;
            end
            default: ;
        endcase
    end

    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_jram_arbiter.sv
// Bench for jram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (memory array, per-port read data, round-robin pointer).
module tb_jram_arbiter;

    logic clk;
    logic reset;
    jram_arbiter_if bus ();

    jram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic       run_chk  = 1'b0;
    logic       ram_clear = 1'b1;

    // RAM environment driven by the DUT strobes.
    logic [7:0] ram [256];
    logic [7:0] mar;

    // Reference model state.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_rdata [2];
    int         ref_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM: MAR loads while wsa is high, location written while ws is high.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5a;
            mar <= 8'h00;
        end else begin
            if (bus.wsa) mar <= bus.bas;
            if (bus.ws) ram[mar] <= bus.bis;
        end
    end
    assign bus.bos = bus.we ? ram[mar] : 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Never more than one strobe high in a cycle.
    always @(negedge clk) begin
        if (run_chk) begin
            check_eq("strobe_excl", 32'((int'(bus.wsa) + int'(bus.ws) + int'(bus.we)) > 1), 32'(0));
        end
    end

    // Per-cycle expectation; e_bas / e_bis of -1 mean the bus is not checked.
    task automatic cyc(input string tag, input logic e_wsa, input logic e_ws, input logic e_we,
                       input logic e_ack0, input logic e_ack1, input int e_bas, input int e_bis,
                       input logic e_busy);
        check_eq({tag, ".wsa"},  32'(bus.wsa),  32'(e_wsa));
        check_eq({tag, ".ws"},   32'(bus.ws),   32'(e_ws));
        check_eq({tag, ".we"},   32'(bus.we),   32'(e_we));
        check_eq({tag, ".ack0"}, 32'(bus.ack0), 32'(e_ack0));
        check_eq({tag, ".ack1"}, 32'(bus.ack1), 32'(e_ack1));
        check_eq({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
        if (e_bas >= 0) check_eq({tag, ".bas"}, 32'(bus.bas), 32'(e_bas));
        if (e_bis >= 0) check_eq({tag, ".bis"}, 32'(bus.bis), 32'(e_bis));
    endtask

    // Round-robin rule: sole requester wins, a tie goes to the port not granted last.
    function automatic int pick();
        if (bus.req0 && bus.req1) return (ref_last == 0) ? 1 : 0;
        return bus.req0 ? 0 : 1;
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        cyc("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check_eq("rst.rdata0", 32'(bus.rdata0), 32'(0));
        check_eq("rst.rdata1", 32'(bus.rdata1), 32'(0));
        @(posedge clk);
        #1;
        reset        = 1'b0;
        ref_last     = 1;
        ref_rdata[0] = 8'h00;
        ref_rdata[1] = 8'h00;
    endtask

    // Called during an IDLE cycle with requests set up; returns in the following IDLE cycle.
    // mode 0: fields untouched, 1: maybe scramble winner's fields in AHOLD,
    // 2: port 0 drops req and moves addr0 to 0x11 in AHOLD.
    task automatic serve(input int p, input int mode);
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        w = p ? bus.rw1 : bus.rw0;
        a = p ? bus.addr1 : bus.addr0;
        d = p ? bus.wdata1 : bus.wdata0;
        @(posedge clk);
        #1;
        cyc("addr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, int'(a), -1, 1'b1);
        @(posedge clk);
        #1;
        cyc("ahold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, int'(a), -1, 1'b1);
        if (mode == 2) begin
            bus.req0  = 1'b0;
            bus.addr0 = 8'h11;
        end else if (mode == 1 && $urandom_range(0, 1) == 1) begin
            if (p == 0) begin
                bus.req0   = 1'($urandom);
                bus.rw0    = 1'($urandom);
                bus.addr0  = 8'($urandom);
                bus.wdata0 = 8'($urandom);
            end else begin
                bus.req1   = 1'($urandom);
                bus.rw1    = 1'($urandom);
                bus.addr1  = 8'($urandom);
                bus.wdata1 = 8'($urandom);
            end
        end
        @(posedge clk);
        #1;
        if (w) begin
            cyc("wset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, int'(d), 1'b1);
            @(posedge clk);
            #1;
            cyc("whold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, int'(d), 1'b1);
            ref_mem[a] = d;
        end else begin
            cyc("rd", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1);
            ref_rdata[p] = ref_mem[a];
        end
        @(posedge clk);
        #1;
        cyc("ack", 1'b0, 1'b0, 1'b0, p == 0, p == 1, -1, -1, 1'b1);
        check_eq("rdata0", 32'(bus.rdata0), 32'(ref_rdata[0]));
        check_eq("rdata1", 32'(bus.rdata1), 32'(ref_rdata[1]));
        ref_last = p;
        if (p == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
        @(posedge clk);
        #1;
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic req_port(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            bus.rw0 = w; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
        end else begin
            bus.rw1 = w; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
        end
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return 8'($urandom_range(0, 7));
        return 8'($urandom);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.rw0    = 1'b0;
        bus.rw1    = 1'b0;
        bus.addr0  = 8'h00;
        bus.addr1  = 8'h00;
        bus.wdata0 = 8'h00;
        bus.wdata1 = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5a;
        do_reset();
        ram_clear = 1'b0;
        run_chk   = 1'b1;

        // Write then read back through the other port.
        req_port(0, 1'b1, 8'h3c, 8'ha5);
        serve(pick(), 0);
        req_port(1, 1'b0, 8'h3c, 8'h00);
        serve(pick(), 0);

        // Simultaneous requests right after reset alternate 0, 1, 0, 1.
        do_reset();
        req_port(0, 1'b1, 8'h50, 8'h12);
        req_port(1, 1'b1, 8'h51, 8'h34);
        serve(pick(), 0);
        serve(pick(), 0);
        req_port(0, 1'b1, 8'h52, 8'h56);
        req_port(1, 1'b1, 8'h53, 8'h78);
        serve(pick(), 0);
        serve(pick(), 0);

        // Reset in WSET: no write lands, no ack.
        req_port(0, 1'b1, 8'h40, 8'h77);
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst.ws", 32'(bus.ws), 32'(1));
        do_reset();
        @(posedge clk);
        #1;
        cyc("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
        req_port(1, 1'b0, 8'h40, 8'h00);
        serve(pick(), 0);

        // Fields changed after grant do not redirect the write.
        req_port(0, 1'b1, 8'h20, 8'hc3);
        serve(pick(), 2);
        req_port(1, 1'b0, 8'h11, 8'h00);
        serve(pick(), 0);
        req_port(0, 1'b0, 8'h20, 8'h00);
        serve(pick(), 0);

        // Extreme addresses are distinct.
        req_port(0, 1'b1, 8'hff, 8'hff);
        serve(pick(), 0);
        req_port(1, 1'b1, 8'h00, 8'h01);
        serve(pick(), 0);
        req_port(0, 1'b0, 8'hff, 8'h00);
        serve(pick(), 0);
        req_port(1, 1'b0, 8'h00, 8'h00);
        serve(pick(), 0);

        // Random traffic.
        for (int it = 0; it < 200; it++) begin
            if (!bus.req0 && $urandom_range(0, 2) != 0) begin
                req_port(0, 1'($urandom), rand_addr(), 8'($urandom));
            end
            if (!bus.req1 && $urandom_range(0, 2) != 0) begin
                req_port(1, 1'($urandom), rand_addr(), 8'($urandom));
            end
            if (!bus.req0 && !bus.req1) begin
                @(posedge clk);
                #1;
                cyc("noreq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
            end else begin
                serve(pick(), 1);
            end
        end

        run_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jram_arbiter.md
# jram_arbiter

Two-port arbiter and sequencer for the 256 x 8 RAM block. It sits between two requesters (CPU control and the I/O/loader port) and the RAM's bus-style interface. It grants one requester at a time, round-robin. It then sequences the RAM strobes: address load into the MAR (`wsa`), then either a write set pulse (`ws`) or a read enable window (`we`). It returns read data and a one-cycle acknowledge.

## Interface
- No parameters. Address and data are fixed at 8 bits to match the RAM.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  transaction request, one per port.
- `rw0`, `rw1`  in  1  1 = write, 0 = read; sampled at grant.
- `addr0`, `addr1`  in  8  RAM address; sampled at grant.
- `wdata0`, `wdata1`  in  8  write data; sampled at grant.
- `ack0`, `ack1`  out  1  one-cycle pulse when the transaction completes.
- `rdata0`, `rdata1`  out  8  registered read data per port; held until that port's next read completes.
- `busy`  out  1  high in every non-IDLE state.
- `bas`  out  8  RAM address bus; driven from the latched address, else 0.
- `wsa`  out  1  MAR set strobe.
- `bis`  out  8  RAM write data bus; driven from the latched data, else 0.
- `ws`  out  1  RAM write set strobe.
- `we`  out  1  RAM output enable.
- `bos`  in  8  RAM read data; valid while `we` is high.

## Operation
- States: IDLE, ADDR, AHOLD, WSET, WHOLD, RD, ACK.
- IDLE
  - If any request is pending, grant one and latch that port's `rw`, `addr` and `wdata` into internal registers.
  - Go to ADDR.
- Arbitration
  - Round-robin using a last-grant pointer.
  - If only one request is pending, that port wins.
  - If both are pending, the port not granted last wins.
  - After reset the pointer is set to port 1, so port 0 wins the first tie.
- ADDR
  - `bas` = latched address, `wsa` = 1.
  - Go to AHOLD.
- AHOLD
  - `wsa` = 0; `bas` held so the MAR latches cleanly on the falling set.
  - Go to WSET if write, RD if read.
- WSET
  - `bis` = latched data, `ws` = 1.
  - Go to WHOLD.
- WHOLD
  - `ws` = 0; `bis` held.
  - Go to ACK.
- RD
  - `we` = 1.
  - `bos` is captured into the granted port's `rdata` on the rising edge that ends RD.
  - Go to ACK.
- ACK
  - The granted port's `ack` = 1; the other port's `ack` stays 0.
  - Update the last-grant pointer.
  - Go to IDLE.
- Strobe exclusivity
  - At most one of `wsa`, `ws`, `we` is high in any cycle.
  - All three are low in IDLE, AHOLD, WHOLD and ACK.
- Requester rule
  - Hold `req` until `ack` is seen.
  - Deassert `req` in the cycle after `ack` unless another transaction is wanted.
  - A `req` still high in IDLE starts a new transaction.
- Request fields are latched at grant. Changing or dropping `req`, `addr`, `rw` or `wdata` after grant does not affect the transaction in flight, which still completes and acks.
- `rdata` of the non-granted port never changes. A write never changes either `rdata`.

## Timing
- Edge E is the rising edge that samples `req` in IDLE.
- Write transaction:
  - cycle E+1: ADDR, `wsa` high.
  - cycle E+2: AHOLD.
  - cycle E+3: WSET, `ws` high.
  - cycle E+4: WHOLD.
  - cycle E+5: ACK.
  - IDLE again at E+6.
- Read transaction:
  - cycle E+1: ADDR.
  - cycle E+2: AHOLD.
  - cycle E+3: RD, `we` high.
  - cycle E+4: ACK, `rdata` already valid.
- Throughput: at most one write per 6 cycles, one read per 5 cycles. IDLE is always visited between transactions.
- Reset state:
  - state = IDLE, pointer = port 1.
  - `busy`, `ack0`, `ack1`, `wsa`, `ws`, `we` = 0.
  - `bas`, `bis`, `rdata0`, `rdata1` = 0x00.
- Reset mid-operation:
  - All outputs go to reset values immediately, without waiting for `clk`.
  - The transaction is abandoned and no ack is issued.
  - RAM contents change only if a `ws` high cycle already occurred.
- Address wrap: none. Addresses 0x00 and 0xFF are ordinary, distinct locations.

## Test plan
- Write, port 0, `addr0`=0x3C, `wdata0`=0xA5:
  - `wsa` high at E+1 with `bas`=0x3C.
  - `ws` high at E+3 with `bis`=0xA5.
  - `ack0` high at E+5 only.
  - `ack1` stays 0 throughout.
- Read, port 1, `addr1`=0x3C, after the write above:
  - `we` high at E+3.
  - `rdata1`=0xA5 and `ack1` high at E+4.
  - `rdata0` unchanged.
- Both ports request writes immediately after reset:
  - Port 0 is served first, then port 1 with no lost request.
  - A repeated simultaneous request is served port 0 then port 1 again (alternation).
- Reset asserted during WSET:
  - `ws`, `bas` and `bis` drop to 0 asynchronously.
  - No ack is issued.
  - Reading that address afterwards returns the data written by the `ws` pulse, if any.
- Port 0 drops `req` and changes `addr0` to 0x11 during AHOLD of a write to 0x20:
  - The write completes to 0x20 and `ack0` is still issued.
  - Address 0x11 is unchanged.
- Write 0xFF to 0xFF, then 0x01 to 0x00, then read both:
  - Reads return 0xFF and 0x01 respectively.
  - No strobe-overlap cycle occurs anywhere (assert `wsa`+`ws`+`we` ≤ 1 every cycle).
